// File: rtl/r4k_memory_if.sv
// Bus bundle between the r4k_core fetch/data ports and the r4k_memory responder.
// The core drives addresses, write data and requests; the memory returns read
// data plus its ready/fault status.
interface r4k_memory_if;
  logic [63:0] data_address;
  logic [63:0] data_out;
  logic [63:0] data_in;
  logic        data_read;
  logic        data_write;
  logic [7:0]  data_mask;
  logic [63:0] instr_address;
  logic [31:0] instr_in;
  logic        instr_read;
  logic        ready;
  logic        fault;

  modport master (
    output data_address, data_out, data_read, data_write, data_mask,
    output instr_address, instr_read,
    input  data_in, instr_in, ready, fault
  );

  modport slave (
    input  data_address, data_out, data_read, data_write, data_mask,
    input  instr_address, instr_read,
    output data_in, instr_in, ready, fault
  );
endinterface

// File: rtl/r4k_memory.sv
// Shared 64-bit word memory serving the r4k_core data and instruction ports.
// After reset a clear sequence zeroes every word, then both ports are served in
// parallel with a fixed one-cycle read latency. A free-running cycle counter is
// mapped at COUNTER_ADDR in the data space. Any bad access sets a sticky fault.
module r4k_memory #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter logic [63:0] COUNTER_ADDR = 64'hFFFF_FFFF_FFFF_FF00
) (
  input logic           clk,
  input logic           reset,
  r4k_memory_if.slave   bus
);

  localparam int unsigned    AW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0]    SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state;
  logic [AW-1:0] clear_idx;
  logic [63:0]   counter;
  logic [63:0]   mem [DEPTH_WORDS];

  logic [63:0]   data_off;
  logic [63:0]   instr_off;
  logic          data_in_range;
  logic          instr_in_range;
  logic          counter_hit;
  logic [AW-1:0] data_idx;
  logic [AW-1:0] instr_idx;
  logic [63:0]   instr_word;
  logic          mask_any;
  logic [63:0]   counter_next;
  logic          data_fault;
  logic          instr_fault;

  // Address decode for both ports. An address below BASE_ADDR wraps to a huge
  // offset, so the single offset < SPAN test covers both range bounds as long
  // as the array fits in the 64-bit address space.
  always_comb begin
    data_off       = bus.data_address - BASE_ADDR;
    instr_off      = bus.instr_address - BASE_ADDR;
    data_in_range  = (data_off < SPAN);
    instr_in_range = (instr_off < SPAN);
    data_idx       = data_off[AW+2:3];
    instr_idx      = instr_off[AW+2:3];
    counter_hit    = (bus.data_address[63:3] == COUNTER_ADDR[63:3]);
    instr_word     = mem[instr_idx];
    mask_any       = (bus.data_mask != 8'h00);
  end

  // Next counter value: a masked write to the counter replaces the increment,
  // with disabled lanes keeping the current (non-incremented) value.
  always_comb begin
    counter_next = counter + 64'd1;
    if (bus.data_write && counter_hit && mask_any) begin
      for (int i = 0; i < 8; i++) begin
        counter_next[8*i +: 8] = bus.data_mask[i] ? bus.data_out[8*i +: 8]
                                                  : counter[8*i +: 8];
      end
    end
  end

  // Fault sources: data access hitting neither the array nor the counter,
  // fetch outside the array, or a fetch not aligned to 4 bytes.
  always_comb begin
    data_fault  = ((bus.data_read && !data_in_range && !counter_hit) ||
                   (bus.data_write && mask_any && !data_in_range && !counter_hit));
    instr_fault = bus.instr_read &&
                  (!instr_in_range || (bus.instr_address[1:0] != 2'b00));
  end

  // Array write port; the array itself cannot be reset, so the clear FSM zeroes
  // it one word per cycle, and only RUN-state writes land afterwards.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clear_idx] <= '0;
    end else if (bus.data_write && data_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.data_mask[i]) begin
          mem[data_idx][8*i +: 8] <= bus.data_out[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered read data, status outputs and cycle counter;
  // reads see pre-edge array contents, giving read-before-write on collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= CLEAR;
      clear_idx    <= '0;
      counter      <= '0;
      bus.data_in  <= '0;
      bus.instr_in <= '0;
      bus.ready    <= 1'b0;
      bus.fault    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == LAST_IDX) begin
            state     <= RUN;
            bus.ready <= 1'b1;
          end
        end
        RUN: begin
          counter <= counter_next;
          if (bus.data_read) begin
            if (data_in_range) begin
              bus.data_in <= mem[data_idx];
            end else if (counter_hit) begin
              bus.data_in <= counter;
            end else begin
              bus.data_in <= '0;
            end
          end
          if (bus.instr_read) begin
            if (instr_in_range) begin
              bus.instr_in <= bus.instr_address[2] ? instr_word[63:32]
                                                   : instr_word[31:0];
            end else begin
              bus.instr_in <= '0;
            end
          end
          if (data_fault || instr_fault) begin
            bus.fault <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r4k_memory.sv
// Self-checking bench for r4k_memory with a 16-word array. Expected read data
// is queued when a request is driven and compared when the monitor sees the
// registered response one edge later.
module tb_r4k_memory;

  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] CNT   = 64'hFFFF_FFFF_FFFF_FF00;

  typedef struct {
    string       tag;
    logic [63:0] val;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  exp_t        data_q[$];
  exp_t        instr_q[$];
  int          total = 0;
  int          passed = 0;
  logic [63:0] last_data = '0;
  logic [63:0] c0;
  logic [63:0] c1;
  logic        mon_dr;
  logic        mon_ir;
  logic        mon_rdy;

  r4k_memory_if bus();

  r4k_memory #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (64'h0),
    .COUNTER_ADDR(CNT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of requests at a falling edge, then return to idle
  task automatic applyStimulus(input logic dr, input logic dw, input logic ir,
                               input logic [63:0] daddr, input logic [63:0] dout,
                               input logic [7:0] mask, input logic [63:0] iaddr);
    bus.data_read     = dr;
    bus.data_write    = dw;
    bus.instr_read    = ir;
    bus.data_address  = daddr;
    bus.data_out      = dout;
    bus.data_mask     = mask;
    bus.instr_address = iaddr;
    @(negedge clk);
    bus.data_read     = 1'b0;
    bus.data_write    = 1'b0;
    bus.instr_read    = 1'b0;
    bus.data_mask     = 8'h00;
  endtask

  task automatic pushData(input string tag, input logic [63:0] val, input bit chk);
    exp_t e;
    e.tag = tag;
    e.val = val;
    e.chk = chk;
    data_q.push_back(e);
  endtask

  task automatic pushInstr(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    e.chk = 1'b1;
    instr_q.push_back(e);
  endtask

  task automatic doRead(input logic [63:0] addr, input string tag,
                        input logic [63:0] val, input bit chk);
    pushData(tag, val, chk);
    applyStimulus(1'b1, 1'b0, 1'b0, addr, 64'h0, 8'h00, 64'h0);
  endtask

  task automatic doWrite(input logic [63:0] addr, input logic [63:0] data,
                         input logic [7:0] mask);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, data, mask, 64'h0);
  endtask

  task automatic doFetch(input logic [63:0] addr, input string tag,
                         input logic [31:0] val);
    pushInstr(tag, 64'(val));
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 8'h00, addr);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h0);
  endtask

  // Count edges after reset release until ready rises, bounded by a budget
  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 64'(n), 64'(DEPTH));
    @(negedge clk);
  endtask

  // Monitor: requests sampled at the edge are checked against the queue 1 unit later
  initial begin
    forever begin
      @(posedge clk);
      mon_dr  = bus.data_read;
      mon_ir  = bus.instr_read;
      mon_rdy = bus.ready;
      #1;
      if (mon_rdy && mon_dr) begin
        checkOutput("data_sb_pending", 64'(data_q.size() != 0), 64'd1);
        if (data_q.size() != 0) begin
          exp_t e;
          e = data_q.pop_front();
          last_data = bus.data_in;
          if (e.chk) checkOutput(e.tag, bus.data_in, e.val);
        end
      end
      if (mon_rdy && mon_ir) begin
        checkOutput("instr_sb_pending", 64'(instr_q.size() != 0), 64'd1);
        if (instr_q.size() != 0) begin
          exp_t e;
          e = instr_q.pop_front();
          checkOutput(e.tag, 64'(bus.instr_in), e.val);
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Main directed sequence
  initial begin
    bus.data_read     = 1'b0;
    bus.data_write    = 1'b0;
    bus.instr_read    = 1'b0;
    bus.data_address  = '0;
    bus.data_out      = '0;
    bus.data_mask     = '0;
    bus.instr_address = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_data_in", bus.data_in, 64'h0);
    checkOutput("rst_instr_in", 64'(bus.instr_in), 64'h0);
    checkOutput("rst_ready", 64'(bus.ready), 64'h0);
    checkOutput("rst_fault", 64'(bus.fault), 64'h0);

    reset = 1'b0;
    waitReady("clear_cycles");
    doRead(64'h40, "clear_word8", 64'h0, 1'b1);
    checkOutput("fault_after_clear", 64'(bus.fault), 64'h0);

    // Masked byte-lane writes
    doWrite(64'h10, 64'h1122334455667788, 8'hFF);
    doWrite(64'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    doRead(64'h10, "masked_merge", 64'h11223344BBBBBBBB, 1'b1);
    doWrite(64'h18, 64'hDEADBEEFCAFEF00D, 8'h00);
    doRead(64'h18, "mask0_nochange", 64'h0, 1'b1);
    checkOutput("mask0_no_fault", 64'(bus.fault), 64'h0);

    // Read/write collision returns old contents
    doWrite(64'h20, 64'd5, 8'hFF);
    pushData("collision_old", 64'd5, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h20, 64'd9, 8'hFF, 64'h0);
    doRead(64'h20, "collision_new", 64'd9, 1'b1);

    // Instruction fetch half selection and misalignment
    doWrite(64'h8, 64'h2108000100000000, 8'hFF);
    doFetch(64'hC, "fetch_hi", 32'h21080001);
    doFetch(64'h8, "fetch_lo", 32'h00000000);
    checkOutput("aligned_fetch_no_fault", 64'(bus.fault), 64'h0);
    doFetch(64'hE, "fetch_misaligned", 32'h21080001);
    checkOutput("misaligned_fault", 64'(bus.fault), 64'h1);
    idle();
    checkOutput("instr_hold", 64'(bus.instr_in), 64'h21080001);

    // Reset mid-run clears outputs immediately and restarts the clear sequence
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midrst_data_in", bus.data_in, 64'h0);
    checkOutput("midrst_instr_in", 64'(bus.instr_in), 64'h0);
    checkOutput("midrst_ready", 64'(bus.ready), 64'h0);
    checkOutput("midrst_fault", 64'(bus.fault), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    waitReady("reclear_cycles");
    doRead(64'h20, "post_reset_cleared", 64'h0, 1'b1);

    // Counter advances once per cycle
    doRead(CNT, "counter_a", 64'h0, 1'b0);
    c0 = last_data;
    idle();
    idle();
    doRead(CNT, "counter_b", 64'h0, 1'b0);
    c1 = last_data;
    checkOutput("counter_delta", c1 - c0, 64'd3);

    // Counter write then wrap
    doWrite(CNT, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    doRead(CNT, "counter_written", 64'hFFFFFFFFFFFFFFFF, 1'b1);
    doRead(CNT, "counter_wrapped", 64'h0, 1'b1);
    checkOutput("counter_no_fault", 64'(bus.fault), 64'h0);

    // Out-of-range access: zero data, sticky fault
    doWrite(64'h28, 64'h77, 8'hFF);
    doRead(64'h28, "word28", 64'h77, 1'b1);
    doRead(64'(DEPTH) * 8, "oor_read", 64'h0, 1'b1);
    checkOutput("oor_fault", 64'(bus.fault), 64'h1);
    idle();
    idle();
    checkOutput("fault_sticky", 64'(bus.fault), 64'h1);
    doFetch(64'h28, "fetch_word28", 32'h00000077);
    doFetch(64'(DEPTH) * 8, "oor_fetch_nop", 32'h00000000);

    idle();
    checkOutput("sb_drained", 64'(data_q.size() + instr_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/r4k_memory.md
Name: r4k_memory

Overview:
Memory responder for the r4k_core fetch and data ports, built for simulation and FPGA bring-up. It holds a single 64-bit-wide word array that serves both ports. On the data side it supports byte-lane masked writes. On the instruction side it returns one 32-bit half-word per fetch. It also maps one free-running cycle-counter register into the data space. After reset it zeroes the whole array with a sequential clear state machine, then serves requests with fixed 1-cycle read latency.

Parameters:
- DEPTH_WORDS, 1024: number of 64-bit words in the array; must be a power of two, at least 2.
- BASE_ADDR, 64'h0: byte address of word 0; must be 8-byte aligned.
- COUNTER_ADDR, 64'hFFFF_FFFF_FFFF_FF00: byte address of the memory-mapped cycle counter; 8-byte aligned and outside the array range.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_address  input  64  data byte address from the core; bits [2:0] are ignored.
- data_out  input  64  write data from the core.
- data_in  output  64  read data to the core.
- data_read  input  1  data read request, sampled each edge.
- data_write  input  1  data write request, sampled each edge.
- data_mask  input  8  write byte enables; bit i enables bits [8i+7:8i].
- instr_address  input  64  fetch byte address.
- instr_in  output  32  fetched instruction.
- instr_read  input  1  fetch request.
- ready  output  1  high once the clear sequence has completed.
- fault  output  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (asynchronous):
  - State goes to CLEAR and clear_idx to 0.
  - Outputs: data_in = 0, instr_in = 0, ready = 0, fault = 0.
  - Counter = 0.
- A reset asserted mid-operation aborts everything and restarts CLEAR. Array contents are undefined until CLEAR finishes.
- CLEAR state:
  - Each cycle writes 64'h0 to word clear_idx and increments clear_idx.
  - After the write of word DEPTH_WORDS-1, moves to RUN, so ready rises exactly DEPTH_WORDS cycles after reset deasserts.
  - In CLEAR, all requests are ignored, data_in and instr_in stay 0, fault does not change, and the counter holds at 0.
- RUN state: persists until reset.
- Address decode:
  - A data access is in range when BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH_WORDS.
  - word index = (addr - BASE_ADDR) >> 3, unsigned 64-bit arithmetic.
  - A counter hit is data_address[63:3] == COUNTER_ADDR[63:3].
- Data read (data_read = 1 at edge N):
  - data_in at edge N+1 = array word, counter value before edge N's update, or 0 if out of range.
  - data_in holds its value until the next sampled read.
- Data write (data_write = 1):
  - Byte lanes with data_mask[i] = 1 are updated at that edge; unmasked lanes keep their contents.
  - data_mask = 0 performs no write and raises no fault.
- Read and write in the same cycle to the same word: read-before-write, so data_in returns the old contents and the write lands.
- Counter:
  - In RUN, increments by 1 every cycle, wrapping 2^64-1 -> 0.
  - A data write hit replaces that cycle's increment: enabled lanes take data_out, disabled lanes take the current value (not incremented).
  - The next cycle resumes incrementing from the written value.
- Instruction fetch (instr_read = 1 at edge N), result at edge N+1:
  - instr_in = word[63:32] if instr_address[2] = 1, otherwise word[31:0].
  - instr_in holds its value while instr_read = 0.
  - A fetch of a word written at the same edge returns the old contents.
  - Fetches never hit the counter; they only decode the array range.
- fault is set at the edge of any of:
  - out-of-range data read, or out-of-range data write with mask != 0 (the write is dropped);
  - out-of-range fetch (instr_in = 32'h0, a NOP);
  - a fetch with instr_address[1:0] != 0. Misaligned fetches still return the selected half-word.
- Both ports serve in parallel every cycle; there is no arbitration and no stall.

Test Plan:
- Reset clear, DEPTH_WORDS = 16: deassert reset and count cycles -> ready rises on edge 16. A read of addr 0x40 issued after ready rises returns 0, and fault = 0.
- Masked write:
  - write 0x1122334455667788 mask 8'hFF to 0x10, then mask 8'h0F with 0xAAAAAAAABBBBBBBB -> reading 0x10 gives 0x11223344BBBBBBBB one cycle later.
  - mask 0 to 0x18 -> no change, no fault.
- Read/write collision: word 0x20 holds 5; read and write 9 (mask FF) to 0x20 in the same cycle -> data_in = 5; the next read gives 9.
- Fetch halves: word 0x8 = 0x2108000100000000 -> fetch 0xC gives 0x21080001 and fetch 0x8 gives 0x00000000. Fetch 0xE gives 0x21080001 and sets fault.
- Counter: read COUNTER_ADDR twice, 3 cycles apart -> the values differ by 3. Write 0xFFFFFFFFFFFFFFFF mask FF -> the counter wraps to 0 one cycle later.
- Out of range and reset: read BASE_ADDR + 8*DEPTH_WORDS -> data_in = 0 and fault = 1 (sticky). Assert reset mid-run -> all outputs 0 immediately; ready returns after DEPTH_WORDS cycles.
